// File: rtl/mul_pipelined.sv
// mul_pipelined: 32x32 -> 64 pipelined integer multiplier, signed or unsigned per operand pair.
// Radix-4 Booth recoding, Wallace tree of 3:2 compressors, final carry-propagate add.
// A pair sampled at rising edge N appears on result just after edge N+2.
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset, clears every pipeline register
//   sign   - 1: x and y are two's complement; 0: both unsigned
//   x      - 32-bit multiplicand
//   y      - 32-bit multiplier
//   result - 64-bit product, registered
module mul_pipelined (
    input  logic        clk,
    input  logic        rst,
    input  logic        sign,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic [63:0] result
);

    localparam int unsigned W    = 32;
    localparam int unsigned PW   = 64;
    localparam int unsigned NPP  = 17;
    localparam int unsigned NROW = NPP + 1;

    // 3:2 compressor: sum row and left-shifted carry row, modulo 2^64
    function automatic logic [PW-1:0] csa_sum(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                              input logic [PW-1:0] c);
        return a ^ b ^ c;
    endfunction

    function automatic logic [PW-1:0] csa_carry(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                                input logic [PW-1:0] c);
        return ((a & b) | (a & c) | (b & c)) << 1;
    endfunction

    logic [W-1:0]  x_q;
    logic [W-1:0]  y_q;
    logic          sign_q;
    logic [PW-1:0] sum_q;
    logic [PW-1:0] carry_q;

    logic [W:0]    xe;
    logic [W:0]    ye;
    logic [W+2:0]  yb;
    logic [PW-1:0] xs;
    logic [PW-1:0] x2;
    logic [PW-1:0] rows [NROW];
    logic [PW-1:0] corr;
    logic [PW-1:0] l1 [12];
    logic [PW-1:0] l2 [8];
    logic [PW-1:0] l3 [6];
    logic [PW-1:0] l4 [4];
    logic [PW-1:0] l5 [3];
    logic [PW-1:0] sum_c;
    logic [PW-1:0] carry_c;

    // Stage 0: operand sampling registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q    <= '0;
            y_q    <= '0;
            sign_q <= 1'b0;
        end else begin
            x_q    <= x;
            y_q    <= y;
            sign_q <= sign;
        end
    end

    // Operand extension to 33 bits so unsigned values ride the signed Booth datapath
    always_comb begin
        xe = {sign_q & x_q[W-1], x_q};
        ye = {sign_q & y_q[W-1], y_q};
        xs = {{(PW-W-1){xe[W]}}, xe};
        x2 = xs << 1;
        // yb[k+1] = ye[k]; yb[0] is the implicit y[-1]; top bit repeats the sign
        yb = {ye[W], ye, 1'b0};
    end

    // Booth recoding: 17 partial products plus one row of negation +1 bits
    always_comb begin
        logic [2:0]    b;
        logic          one;
        logic          two;
        logic          neg;
        logic [PW-1:0] mag;
        logic [PW-1:0] t;
        corr = '0;
        b    = '0;
        one  = 1'b0;
        two  = 1'b0;
        neg  = 1'b0;
        mag  = '0;
        t    = '0;
        for (int i = 0; i < NROW; i++) begin
            rows[i] = '0;
        end
        for (int i = 0; i < NPP; i++) begin
            b   = yb[2*i +: 3];
            one = b[1] ^ b[0];
            two = (b[2] & ~b[1] & ~b[0]) | (~b[2] & b[1] & b[0]);
            // digit 111 is zero: leave neg clear so no stray +1 is injected
            neg = b[2] & ~(b[1] & b[0]);
            mag = ({PW{one}} & xs) | ({PW{two}} & x2);
            t   = mag ^ {PW{neg}};
            // shifting after inversion leaves zeros below 2i, so only +1 at bit 2i is needed
            rows[i]    = t << (2 * i);
            corr[2*i]  = neg;
        end
        rows[NROW-1] = corr;
    end

    // Wallace tree: 18 -> 12 -> 8 -> 6 -> 4 -> 3 -> 2 rows
    always_comb begin
        for (int g = 0; g < 6; g++) begin
            l1[2*g]   = csa_sum  (rows[3*g], rows[3*g+1], rows[3*g+2]);
            l1[2*g+1] = csa_carry(rows[3*g], rows[3*g+1], rows[3*g+2]);
        end
        for (int g = 0; g < 4; g++) begin
            l2[2*g]   = csa_sum  (l1[3*g], l1[3*g+1], l1[3*g+2]);
            l2[2*g+1] = csa_carry(l1[3*g], l1[3*g+1], l1[3*g+2]);
        end
        for (int g = 0; g < 2; g++) begin
            l3[2*g]   = csa_sum  (l2[3*g], l2[3*g+1], l2[3*g+2]);
            l3[2*g+1] = csa_carry(l2[3*g], l2[3*g+1], l2[3*g+2]);
        end
        l3[4] = l2[6];
        l3[5] = l2[7];
        for (int g = 0; g < 2; g++) begin
            l4[2*g]   = csa_sum  (l3[3*g], l3[3*g+1], l3[3*g+2]);
            l4[2*g+1] = csa_carry(l3[3*g], l3[3*g+1], l3[3*g+2]);
        end
        l5[0]   = csa_sum  (l4[0], l4[1], l4[2]);
        l5[1]   = csa_carry(l4[0], l4[1], l4[2]);
        l5[2]   = l4[3];
        sum_c   = csa_sum  (l5[0], l5[1], l5[2]);
        carry_c = csa_carry(l5[0], l5[1], l5[2]);
    end

    // Stage 1: carry-save vectors
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= '0;
        end else begin
            sum_q   <= sum_c;
            carry_q <= carry_c;
        end
    end

    // Stage 2: final carry-propagate add
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
        end else begin
            result <= sum_q + carry_q;
        end
    end

endmodule

// File: tb/tb_mul_pipelined.sv
// tb_mul_pipelined: self-checking bench for mul_pipelined against a delayed
// 64-bit product model, with directed literal checks and random streaming.
module tb_mul_pipelined;

    logic        clk;
    logic        rst;
    logic        sign;
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] result;

    int tests;
    int fails;

    logic [63:0] m_in;
    logic [63:0] m_mid;
    logic [63:0] m_out;

    mul_pipelined dut (
        .clk    (clk),
        .rst    (rst),
        .sign   (sign),
        .x      (x),
        .y      (y),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_prod(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'h0, a} * {32'h0, b};
    endfunction

    // Model: product of the pair sampled at each edge, delayed two further edges
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_in  <= '0;
            m_mid <= '0;
            m_out <= '0;
        end else begin
            m_in  <= ref_prod(sign, x, y);
            m_mid <= m_in;
            m_out <= m_mid;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        tests++;
        if (result !== m_out) begin
            fails++;
            $display("FAIL cycle_compare t=%0t result=%h expected=%h", $time, result, m_out);
        end
    end

    task automatic check(input string name, input logic [63:0] exp);
        tests++;
        if (result !== exp) begin
            fails++;
            $display("FAIL %s result=%h expected=%h", name, result, exp);
        end
    endtask

    task automatic check_model(input string name, input logic [63:0] exp);
        tests++;
        if (m_out !== exp) begin
            fails++;
            $display("FAIL model_%s model=%h expected=%h", name, m_out, exp);
        end
    endtask

    // Hold a pair for three negedges, then check DUT and model against a literal
    task automatic apply_lit(input string name, input logic s, input logic [31:0] a,
                             input logic [31:0] b, input logic [63:0] exp);
        @(negedge clk);
        sign = s;
        x    = a;
        y    = b;
        repeat (3) @(negedge clk);
        #1;
        check(name, exp);
        check_model(name, exp);
    endtask

    logic        st_s   [8];
    logic [31:0] st_x   [8];
    logic [31:0] st_y   [8];
    logic [63:0] st_exp [8];
    logic [31:0] corners [5];

    initial begin
        tests = 0;
        fails = 0;
        st_s[0] = 1'b0; st_x[0] = 32'd3;         st_y[0] = 32'd5;         st_exp[0] = 64'h000000000000000F;
        st_s[1] = 1'b1; st_x[1] = 32'hFFFFFFFD;  st_y[1] = 32'd5;         st_exp[1] = 64'hFFFFFFFFFFFFFFF1;
        st_s[2] = 1'b1; st_x[2] = 32'd7;         st_y[2] = 32'hFFFFFFF9;  st_exp[2] = 64'hFFFFFFFFFFFFFFCF;
        st_s[3] = 1'b0; st_x[3] = 32'd65536;     st_y[3] = 32'd65536;     st_exp[3] = 64'h0000000100000000;
        st_s[4] = 1'b0; st_x[4] = 32'hFFFFFFFF;  st_y[4] = 32'hFFFFFFFF;  st_exp[4] = 64'hFFFFFFFE00000001;
        st_s[5] = 1'b1; st_x[5] = 32'h12345678;  st_y[5] = 32'd0;         st_exp[5] = 64'h0;
        st_s[6] = 1'b0; st_x[6] = 32'hFFFFFFFE;  st_y[6] = 32'd3;         st_exp[6] = 64'h00000002FFFFFFFA;
        st_s[7] = 1'b1; st_x[7] = 32'h80000000;  st_y[7] = 32'hFFFFFFFF;  st_exp[7] = 64'h0000000080000000;
        corners[0] = 32'h0;
        corners[1] = 32'h1;
        corners[2] = 32'hFFFFFFFF;
        corners[3] = 32'h80000000;
        corners[4] = 32'h7FFFFFFF;

        // Basic signed with reset
        rst  = 1'b1;
        sign = 1'b1;
        x    = 32'd1314;
        y    = 32'd9999;
        repeat (3) @(negedge clk);
        #1;
        check("reset_hold", 64'h0);
        rst = 1'b0;
        @(negedge clk); #1;
        check("post_reset_edge1", 64'h0);
        @(negedge clk); #1;
        check("post_reset_edge2", 64'h0);
        @(negedge clk); #1;
        check("basic_signed", 64'h0000000000C87AFE);
        check_model("basic_signed", 64'h0000000000C87AFE);

        // Sign handling and extremes
        apply_lit("s_m1_m1",     1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001);
        apply_lit("u_m1_m1",     1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
        apply_lit("s_m1_1",      1'b1, 32'hFFFFFFFF, 32'd1,        64'hFFFFFFFFFFFFFFFF);
        apply_lit("u_m1_1",      1'b0, 32'hFFFFFFFF, 32'd1,        64'h00000000FFFFFFFF);
        apply_lit("s_min_sq",    1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000);
        apply_lit("u_min_sq",    1'b0, 32'h80000000, 32'h80000000, 64'h4000000000000000);
        apply_lit("s_min_max",   1'b1, 32'h80000000, 32'h7FFFFFFF, 64'hC000000080000000);
        apply_lit("zero_x_s",    1'b1, 32'h0,        32'hDEADBEEF, 64'h0);
        apply_lit("zero_x_u",    1'b0, 32'h0,        32'hFFFFFFFF, 64'h0);

        // Streaming: one pair per cycle, results in order two edges later
        for (int j = 0; j < 11; j++) begin
            @(negedge clk);
            if (j >= 3) begin
                #1;
                check($sformatf("stream_%0d", j - 3), st_exp[j-3]);
            end
            if (j < 8) begin
                sign = st_s[j];
                x    = st_x[j];
                y    = st_y[j];
            end else begin
                sign = 1'b0;
                x    = $urandom;
                y    = $urandom;
            end
        end

        // Reset mid-operation: in-flight products must never appear
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_reset_now", 64'h0);
        @(negedge clk);
        sign = 1'b1;
        x    = 32'h7FFFFFFF;
        y    = 32'h7FFFFFFF;
        @(negedge clk);
        #1;
        check("reset_held", 64'h0);
        rst  = 1'b0;
        sign = 1'b0;
        x    = 32'd6;
        y    = 32'd7;
        @(negedge clk); #1;
        check("after_release_1", 64'h0);
        @(negedge clk); #1;
        check("after_release_2", 64'h0);
        @(negedge clk); #1;
        check("after_release_res", 64'd42);

        // Random stream, corner values mixed in
        for (int k = 0; k < 12000; k++) begin
            @(negedge clk);
            sign = 1'($urandom);
            x    = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            y    = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
        end
        repeat (4) @(negedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
